lsp_root_bisect: RTL and testbench

//  Refines one LSP root inside the lpc_to_lsp search. It runs a fixed-count bisection between xl and xr once the

---
 rtl/lsp_root_bisect.sv | 142 ++++++++++++++
 tb/tb_lsp_root_bisect.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsp_root_bisect.sv
// Fixed-count sign-magnitude bisection of one LSP root bracket.
// Each midpoint is handed to the shared Chebyshev evaluator and bracketed on the sign of the result.
module lsp_root_bisect #(
    parameter int N    = 32,
    parameter int Q    = 16,
    parameter int ITER = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         startbs,
    input  logic [N-1:0] xl,
    input  logic [N-1:0] xr,
    input  logic [N-1:0] psuml,
    input  logic [N-1:0] sum_in,
    input  logic         donecp,
    output logic         startcp,
    output logic [N-1:0] x_eval,
    output logic [N-1:0] root,
    output logic [N-1:0] psum_out,
    output logic         busy,
    output logic         donebs
);

    if (ITER < 1 || ITER > 15 || Q >= N) begin : g_param_err
        $error("lsp_root_bisect: ITER must be 1..15 and Q < N");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MID,
        S_START,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_xl;
    logic [N-1:0] r_xr;
    logic [N-1:0] r_psuml;
    logic [N-1:0] r_psumm;
    logic [3:0]   r_k;

    logic [N-1:0] w_xm;
    logic [3:0]   w_k_next;
    logic         w_same;

    // Magnitudes are widened to N bits so a sum that carries past bit N-2 survives the halving.
    function automatic logic [N-1:0] sm_mid(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] ma;
        logic [N-1:0] mb;
        logic [N-1:0] mag;
        logic         s;
        ma = {1'b0, a[N-2:0]};
        mb = {1'b0, b[N-2:0]};
        if (a[N-1] == b[N-1]) begin
            mag = (ma + mb) >> 1;
            s   = a[N-1];
        end else if (ma >= mb) begin
            mag = (ma - mb) >> 1;
            s   = a[N-1];
        end else begin
            mag = (mb - ma) >> 1;
            s   = b[N-1];
        end
        if (mag == '0) s = 1'b0;
        return mag | {s, {(N-1){1'b0}}};
    endfunction

    // A zero on either side (including negative zero) never counts as "same sign".
    function automatic logic sm_same_sign(input logic [N-1:0] a, input logic [N-1:0] b);
        return (a[N-2:0] != '0) && (b[N-2:0] != '0) && (a[N-1] == b[N-1]);
    endfunction

    assign w_xm     = sm_mid(r_xl, r_xr);
    assign w_k_next = r_k + 4'd1;
    assign w_same   = sm_same_sign(r_psumm, r_psuml);

    // x_eval carries the current midpoint through UPDATE and DONE, after the bracket has moved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            startcp  <= 1'b0;
            x_eval   <= '0;
            root     <= '0;
            psum_out <= '0;
            busy     <= 1'b0;
            donebs   <= 1'b0;
            r_k      <= '0;
        end else begin
            startcp <= 1'b0;
            donebs  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (startbs) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_xl    <= xl;
                    r_xr    <= xr;
                    r_psuml <= psuml;
                    r_k     <= '0;
                    busy    <= 1'b1;
                    r_state <= S_MID;
                end
                S_MID: begin
                    x_eval  <= w_xm;
                    startcp <= 1'b1;
                    r_state <= S_START;
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (donecp) begin
                        r_psumm <= sum_in;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (w_same) begin
                        r_psuml <= r_psumm;
                        r_xl    <= x_eval;
                    end else begin
                        r_xr <= x_eval;
                    end
                    r_k     <= w_k_next;
                    r_state <= (w_k_next == 4'(ITER)) ? S_DONE : S_MID;
                end
                S_DONE: begin
                    root     <= x_eval;
                    psum_out <= r_psumm;
                    donebs   <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsp_root_bisect.sv
// Bench for lsp_root_bisect: mock evaluator f(x) = x - c, directed table, corner sequences, random runs.
module tb_lsp_root_bisect;

    localparam int ITER = 4;
    localparam int C03  = 32'h4CCC;

    logic        clk;
    logic        rst;
    logic        startbs;
    logic [31:0] xl;
    logic [31:0] xr;
    logic [31:0] psuml;
    logic [31:0] sum_in;
    logic        donecp;
    logic        startcp;
    logic [31:0] x_eval;
    logic [31:0] root;
    logic [31:0] psum_out;
    logic        busy;
    logic        donebs;

    lsp_root_bisect #(.N(32), .Q(16), .ITER(ITER)) dut (
        .clk(clk), .rst(rst), .startbs(startbs), .xl(xl), .xr(xr), .psuml(psuml),
        .sum_in(sum_in), .donecp(donecp), .startcp(startcp), .x_eval(x_eval),
        .root(root), .psum_out(psum_out), .busy(busy), .donebs(donebs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Mock evaluator controls (written by the main process only)
    int tcp_cfg  = 4;
    int c_off    = C03;
    int zero_abs = -1;
    int inj_req  = 0;

    // Mock evaluator / monitor state (written by the mock process only)
    logic [31:0] xq[$];
    int          ev_idx   = 0;
    int          unstable = 0;
    int          sc_dbl   = 0;
    int          inj_ack  = 0;
    bit          pending  = 0;
    bit          sc_prev  = 0;
    int          cnt      = 0;
    logic [31:0] held_x   = '0;

    function automatic longint to_int(input logic [31:0] v);
        longint m;
        m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    function automatic logic [31:0] to_sm(input longint v);
        longint m;
        m = (v < 0) ? -v : v;
        return {(v < 0) && (m != 0), m[30:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        donecp = 1'b0;
        if (startcp) begin
            if (sc_prev) sc_dbl++;
            xq.push_back(x_eval);
            held_x  = x_eval;
            pending = 1'b1;
            cnt     = tcp_cfg;
        end else if (pending) begin
            if (x_eval != held_x) unstable++;
            cnt--;
            if (cnt <= 0) begin
                donecp  = 1'b1;
                sum_in  = (ev_idx == zero_abs) ? 32'h80000000 : to_sm(to_int(x_eval) - longint'(c_off));
                ev_idx++;
                pending = 1'b0;
            end
        end else if (inj_req != inj_ack) begin
            inj_ack++;
            donecp = 1'b1;
            sum_in = 32'h00001234;
        end
        sc_prev = startcp;
    end

    typedef struct {
        logic [31:0] xl;
        logic [31:0] xr;
        logic [31:0] psl;
        int          zk;
        logic [31:0] x0;
        logic [31:0] root;
        logic [31:0] psum;
    } vec_t;

    vec_t tbl[8];

    // Reference: plain signed-integer bisection, halving truncates toward zero.
    task automatic run_txn(input logic [31:0] a_xl, input logic [31:0] a_xr, input logic [31:0] a_psl,
                           input int a_c, input int a_zk, input int a_tcp, input bit poke);
        logic [31:0] mx[ITER];
        logic [31:0] m_root, m_psum;
        longint vl, vr, pl, vm, pm;
        int base, ub, db, cyc, lim;
        vl = to_int(a_xl);
        vr = to_int(a_xr);
        pl = to_int(a_psl);
        m_root = '0;
        m_psum = '0;
        for (int k = 0; k < ITER; k++) begin
            vm    = (vl + vr) / 2;
            mx[k] = to_sm(vm);
            pm    = (k == a_zk) ? 0 : vm - longint'(a_c);
            if (pm != 0 && pl != 0 && ((pm > 0) == (pl > 0))) begin
                pl = pm;
                vl = vm;
            end else begin
                vr = vm;
            end
            m_root = to_sm(vm);
            m_psum = (k == a_zk) ? 32'h80000000 : to_sm(pm);
        end

        tcp_cfg  = a_tcp;
        c_off    = a_c;
        zero_abs = (a_zk < 0) ? -1 : ev_idx + a_zk;
        base     = xq.size();
        ub       = unstable;
        db       = sc_dbl;
        lim      = ITER * (a_tcp + 10) + 20;

        @(negedge clk);
        xl = a_xl; xr = a_xr; psuml = a_psl; startbs = 1'b1;
        @(negedge clk);
        startbs = 1'b0;
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (poke) begin
            repeat (2) @(negedge clk);
            xl = 32'h00123456; xr = 32'h80011111; startbs = 1'b1;
            @(negedge clk);
            startbs = 1'b0;
        end
        cyc = 0;
        while (donebs !== 1'b1 && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        chk("donebs_seen", {31'd0, donebs}, 32'd1);
        chk("root", root, m_root);
        chk("psum_out", psum_out, m_psum);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("donebs_width", {31'd0, donebs}, 32'd0);
        chk("startcp_pulses", xq.size() - base, ITER);
        for (int k = 0; k < ITER; k++)
            if (base + k < xq.size()) chk($sformatf("x_eval[%0d]", k), xq[base + k], mx[k]);
        chk("startcp_single", sc_dbl - db, 0);
        chk("x_eval_stable", unstable - ub, 0);
    endtask

    initial begin
        logic [31:0] rxl, rxr, rps;
        int rc, rzk;
        int cyc;

        tbl[0] = '{32'h00008000, 32'h00004000, 32'h00003333, -1, 32'h00006000, 32'h00004C00, 32'h800000CC};
        tbl[1] = '{32'h80004000, 32'h00004000, 32'h80008CCC, -1, 32'h00000000, 32'h00003800, 32'h800014CC};
        tbl[2] = '{32'h00008000, 32'h00004000, 32'h00003333,  0, 32'h00006000, 32'h00006400, 32'h00001734};
        tbl[3] = '{32'h00012345, 32'h00012345, 32'h00000100, -1, 32'h00012345, 32'h00012345, 32'h0000D679};
        tbl[4] = '{32'h80010000, 32'h80020000, 32'h80001000, -1, 32'h80018000, 32'h8001F000, 32'h80023CCC};
        tbl[5] = '{32'h7FFFFFFF, 32'h7FFFFFFD, 32'h00000100, -1, 32'h7FFFFFFE, 32'h7FFFFFFD, 32'h7FFFB331};
        tbl[6] = '{32'h00004000, 32'h00008000, 32'h80000CCC, -1, 32'h00006000, 32'h00004C00, 32'h800000CC};
        tbl[7] = '{32'h80000003, 32'h00000000, 32'h80000100, -1, 32'h80000001, 32'h00000000, 32'h80004CCC};

        rst = 1'b1; startbs = 1'b0; xl = '0; xr = '0; psuml = '0;
        repeat (3) @(negedge clk);
        chk("rst_startcp", {31'd0, startcp}, 32'd0);
        chk("rst_x_eval", x_eval, 32'd0);
        chk("rst_root", root, 32'd0);
        chk("rst_psum", psum_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_donebs", {31'd0, donebs}, 32'd0);
        rst = 1'b0;

        inj_req++;
        repeat (4) @(negedge clk);
        chk("idle_donecp_busy", {31'd0, busy}, 32'd0);
        chk("idle_donecp_startcp", {31'd0, startcp}, 32'd0);
        chk("idle_donecp_root", root, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].xl, tbl[i].xr, tbl[i].psl, C03, tbl[i].zk, 34, i == 0);
            chk($sformatf("tbl%0d_x0", i), xq[xq.size() - ITER], tbl[i].x0);
            chk($sformatf("tbl%0d_root", i), root, tbl[i].root);
            chk($sformatf("tbl%0d_psum", i), psum_out, tbl[i].psum);
        end
        chk("tbl0_psum_neg", {31'd0, tbl[0].psum[31]}, 32'd1);

        // Stalled evaluator
        run_txn(32'h00008000, 32'h00004000, 32'h00003333, C03, -1, 200, 1'b0);
        chk("stall_root", root, 32'h00004C00);

        // Reset while waiting on the evaluator, then a late donecp, then a clean run
        tcp_cfg = 30;
        @(negedge clk);
        xl = 32'h00008000; xr = 32'h00004000; psuml = 32'h00003333; startbs = 1'b1;
        @(negedge clk);
        startbs = 1'b0;
        cyc = 0;
        while (startcp !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_startcp_seen", {31'd0, startcp}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_startcp", {31'd0, startcp}, 32'd0);
        chk("abort_x_eval", x_eval, 32'd0);
        chk("abort_root", root, 32'd0);
        chk("abort_psum", psum_out, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_donebs", {31'd0, donebs}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("late_donecp_busy", {31'd0, busy}, 32'd0);
        chk("late_donecp_startcp", {31'd0, startcp}, 32'd0);
        run_txn(32'h00008000, 32'h00004000, 32'h00003333, C03, -1, 34, 1'b0);
        chk("after_abort_root", root, 32'h00004C00);

        for (int i = 0; i < 30; i++) begin
            rxl = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h001FFFFF))};
            rxr = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h001FFFFF))};
            rps = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h001FFFFF))};
            rc  = int'($urandom_range(0, 32'h00200000)) - 32'sh00100000;
            rzk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ITER - 1)) : -1;
            run_txn(rxl, rxr, rps, rc, rzk, int'($urandom_range(1, 8)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
